// File: rtl/uart_io_pkg.sv
// uart_io_bridge shared package: protocol byte codes, response
// buffer sizing and the bridge FSM state type.
package uart_io_pkg;

  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_CLEAR   = 8'h43;
  localparam logic [7:0] RSP_ACK     = 8'h41;
  localparam logic [7:0] RSP_NAK     = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;
  localparam logic [7:0] RSP_STATUS  = 8'h53;

  // header byte plus up to four switch bytes
  localparam int RSP_W = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_PAYLOAD,
    ST_TX_LOAD,
    ST_TX_WAIT_BUSY,
    ST_TX_WAIT_DONE
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, parametrised width, resets to zero.
// Ports: clk, rst_n, d (async input), q (synchronized).
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver. Ports: clk, rst_n, rx (serial in),
// rx_data (byte), rx_ready (one-cycle strobe at stop-bit middle).
module uart_rx_module #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);

  logic          rx_m;
  logic          rx_s;
  logic          active;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      active   <= 1'b0;
      bit_cnt  <= '0;
      clk_cnt  <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_ready <= 1'b0;
      if (!active) begin
        if (!rx_s) begin
          active  <= 1'b1;
          clk_cnt <= '0;
          bit_cnt <= '0;
        end
      end else if (bit_cnt == 4'd0) begin
        if (clk_cnt == HALF) begin
          clk_cnt <= '0;
          // a glitch that is high again mid-start is no frame
          if (rx_s) active <= 1'b0;
          else bit_cnt <= 4'd1;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
      end else if (clk_cnt == FULL) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active   <= 1'b0;
          rx_ready <= rx_s;
        end else begin
          rx_data <= {rx_s, rx_data[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter. Ports: clk, rst_n, tx_start, tx_data,
// tx (serial out, idles high), tx_busy (frame in progress).
module uart_tx_module #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);

  logic [9:0]    sh;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '1;
      bit_cnt <= '0;
      clk_cnt <= '0;
      tx_busy <= 1'b0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        sh      <= {1'b1, tx_data, 1'b0};
        bit_cnt <= '0;
        clk_cnt <= '0;
        tx_busy <= 1'b1;
      end
    end else if (clk_cnt == FULL) begin
      clk_cnt <= '0;
      sh      <= {1'b1, sh[9:1]};
      if (bit_cnt == 4'd9) tx_busy <= 1'b0;
      else bit_cnt <= bit_cnt + 1'b1;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  assign tx = tx_busy ? sh[0] : 1'b1;

endmodule

// File: rtl/uart_io_bridge.sv
// Switch/LED bank bridge to a host over UART: R/W/C commands with ack,
// error and timeout replies. Ports: clk, rst_n, switches, leds, uart_rx,
// uart_tx, cmd_err, busy. Optional macro: UART_IO_AUTO_REPORT_EN.
module uart_io_bridge
  import uart_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SW_BYTES     = 1,
  parameter int LED_BYTES    = 1,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*SW_BYTES-1:0]  switches,
  output logic [8*LED_BYTES-1:0] leds,
  input  logic                   uart_rx,
  output logic                   uart_tx,
  output logic                   cmd_err,
  output logic                   busy
);

  localparam int SW_W = 8 * SW_BYTES;
  localparam int LW   = 8 * LED_BYTES;
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [2:0] RD_LEN = 3'(SW_BYTES + 1);
  localparam logic [1:0] PAY_LAST = 2'(LED_BYTES - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CLKS);

  if (SW_BYTES < 1 || SW_BYTES > 4) begin : g_sw_chk
    $fatal(1, "uart_io_bridge: SW_BYTES must be 1..4");
  end
  if (LED_BYTES < 1 || LED_BYTES > 4) begin : g_led_chk
    $fatal(1, "uart_io_bridge: LED_BYTES must be 1..4");
  end
  if (TIMEOUT_CLKS < 1) begin : g_to_chk
    $fatal(1, "uart_io_bridge: TIMEOUT_CLKS must be >= 1");
  end

  state_e            state;
  state_e            state_d;
  logic [SW_W-1:0]   sw_sync;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [7:0]        cmd;
  logic [LW-1:0]     shadow;
  logic [LW-1:0]     shadow_d;
  logic [1:0]        pay_cnt;
  logic [TW-1:0]     to_cnt;
  logic [RSP_W-1:0]  rsp_buf;
  logic [2:0]        rsp_left;
  logic              pay_last;
  logic              timeout;
  logic              rep_fire;

  sync_2ff #(.WIDTH(SW_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switches),
    .q     (sw_sync)
  );

  uart_rx_module #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (uart_rx),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  uart_tx_module #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (uart_tx),
    .tx_busy  (tx_busy)
  );

`ifdef UART_IO_AUTO_REPORT_EN
  logic [SW_W-1:0] sw_prev;
  logic [SW_W-1:0] last_rep;
  logic [9:0]      db_cnt;

  // db_cnt saturates once the value has held for 1024 clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev <= '0;
      db_cnt  <= '0;
    end else begin
      sw_prev <= sw_sync;
      if (sw_sync != sw_prev) db_cnt <= '0;
      else if (db_cnt != 10'h3FF) db_cnt <= db_cnt + 1'b1;
    end
  end

  assign rep_fire = (state == ST_IDLE) && !rx_ready &&
                    (db_cnt == 10'h3FF) &&
                    (sw_sync == sw_prev) &&
                    (sw_sync != last_rep);
`else
  assign rep_fire = 1'b0;
`endif

  assign busy     = (state != ST_IDLE);
  assign pay_last = rx_ready && (pay_cnt == PAY_LAST);
  assign timeout  = !rx_ready && (to_cnt == TO_MAX);

  // shadow with the byte arriving this cycle merged in
  always_comb begin
    shadow_d = shadow;
    for (int i = 0; i < LED_BYTES; i++) begin
      if (pay_cnt == 2'(i)) shadow_d[8*i +: 8] = rx_data;
    end
  end

  always_comb begin
    state_d  = state;
    tx_start = 1'b0;
    tx_data  = rsp_buf[7:0];
    unique case (state)
      ST_IDLE: begin
        if (rx_ready) state_d = ST_DECODE;
        else if (rep_fire) state_d = ST_TX_LOAD;
      end
      ST_DECODE: begin
        if (cmd == CMD_WRITE) state_d = ST_PAYLOAD;
        else state_d = ST_TX_LOAD;
      end
      ST_PAYLOAD: begin
        if (pay_last || timeout) state_d = ST_TX_LOAD;
      end
      ST_TX_LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_TX_WAIT_BUSY;
        end
      end
      ST_TX_WAIT_BUSY: begin
        if (tx_busy) state_d = ST_TX_WAIT_DONE;
      end
      ST_TX_WAIT_DONE: begin
        if (!tx_busy) begin
          if (rsp_left == 3'd1) state_d = ST_IDLE;
          else state_d = ST_TX_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      leds     <= '0;
      shadow   <= '0;
      pay_cnt  <= '0;
      to_cnt   <= '0;
      rsp_buf  <= '0;
      rsp_left <= 3'd1;
      cmd_err  <= 1'b0;
`ifdef UART_IO_AUTO_REPORT_EN
      last_rep <= '0;
`endif
    end else begin
      cmd_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_ready) begin
            cmd <= rx_data;
            // clear acts on the edge right after the command byte
            if (rx_data == CMD_CLEAR) leds <= '0;
          end else if (rep_fire) begin
            rsp_buf  <= RSP_W'({sw_sync, RSP_STATUS});
            rsp_left <= RD_LEN;
`ifdef UART_IO_AUTO_REPORT_EN
            last_rep <= sw_sync;
`endif
          end
        end
        ST_DECODE: begin
          pay_cnt  <= '0;
          to_cnt   <= '0;
          shadow   <= '0;
          rsp_left <= 3'd1;
          unique case (1'b1)
            (cmd == CMD_READ): begin
              rsp_buf  <= RSP_W'({sw_sync, CMD_READ});
              rsp_left <= RD_LEN;
            end
            (cmd == CMD_WRITE): begin
              rsp_buf <= RSP_W'(RSP_ACK);
            end
            (cmd == CMD_CLEAR): begin
              rsp_buf <= RSP_W'(RSP_ACK);
            end
            default: begin
              rsp_buf <= RSP_W'(RSP_NAK);
              cmd_err <= 1'b1;
            end
          endcase
        end
        ST_PAYLOAD: begin
          if (rx_ready) begin
            shadow  <= shadow_d;
            pay_cnt <= pay_cnt + 1'b1;
            to_cnt  <= '0;
            if (pay_last) begin
              leds    <= shadow_d;
              rsp_buf <= RSP_W'(RSP_ACK);
            end
          end else if (timeout) begin
            cmd_err <= 1'b1;
            rsp_buf <= RSP_W'(RSP_TIMEOUT);
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_TX_WAIT_DONE: begin
          if (!tx_busy) begin
            rsp_buf  <= rsp_buf >> 8;
            rsp_left <= rsp_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed bench for uart_io_bridge: vector table plus
// hand sequences for timeout, LED timing and mid-reply reset.
module tb_uart_io_bridge;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] switches = 16'hA55A;
  logic [15:0] leds;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        cmd_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_io_bridge #(
    .CLKS_PER_BIT (CPB),
    .SW_BYTES     (2),
    .LED_BYTES    (2),
    .TIMEOUT_CLKS (400)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .switches (switches),
    .leds     (leds),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .cmd_err  (cmd_err),
    .busy     (busy)
  );

  // serial monitor on uart_tx, aborts on reset
  logic [7:0] rx_q[$];
  logic       mact = 1'b0;
  int         mcnt = 0;
  logic [7:0] msh = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mact = 1'b0;
    end else if (!mact) begin
      if (!uart_tx) begin
        mact = 1'b1;
        mcnt = 0;
      end
    end else begin
      mcnt++;
      if (mcnt >= 12 && mcnt <= 68 && (mcnt - 12) % 8 == 0)
        msh = {uart_tx, msh[7:1]};
      if (mcnt == 76) begin
        mact = 1'b0;
        rx_q.push_back(msh);
      end
    end
  end

  int   err_cyc = 0;
  int   err_pls = 0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (cmd_err) err_cyc++;
    if (cmd_err && !err_prev) err_pls++;
    err_prev = cmd_err;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_rsp(input int n, input int lim);
    int k = 0;
    while (rx_q.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
  endtask

  typedef struct {
    string           name;
    logic [15:0]     sw;
    int              nc;
    logic [2:0][7:0] c;
    int              nr;
    logic [2:0][7:0] r;
    logic [15:0]     led;
    int              errs;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int e0c;
    int e0p;
    rx_q.delete();
    switches = v.sw;
    repeat (4) @(negedge clk);
    e0c = err_cyc;
    e0p = err_pls;
    for (int i = 0; i < v.nc; i++) send_byte(v.c[i]);
    wait_rsp(v.nr, 3000);
    repeat (120) @(negedge clk);
    chk({v.name, "_nrsp"}, rx_q.size(), v.nr);
    for (int i = 0; i < v.nr; i++) begin
      if (i < rx_q.size())
        chk($sformatf("%s_b%0d", v.name, i), rx_q[i], v.r[i]);
    end
    chk({v.name, "_leds"}, leds, v.led);
    chk({v.name, "_errp"}, err_pls - e0p, v.errs);
    chk({v.name, "_errc"}, err_cyc - e0c, v.errs);
    chk({v.name, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int e0;
    vecs[0] = '{"rd",  16'hA55A, 1, 24'h000052,
                3, 24'hA55A52, 16'h0000, 0};
    vecs[1] = '{"wr",  16'hA55A, 3, 24'h123457,
                1, 24'h000041, 16'h1234, 0};
    vecs[2] = '{"clr", 16'hA55A, 1, 24'h000043,
                1, 24'h000041, 16'h0000, 0};
    vecs[3] = '{"bad", 16'hA55A, 1, 24'h00007E,
                1, 24'h00003F, 16'h0000, 1};
    vecs[4] = '{"wr2", 16'hA55A, 3, 24'h567857,
                1, 24'h000041, 16'h5678, 0};
    vecs[5] = '{"rd2", 16'hA55A, 1, 24'h000052,
                3, 24'hA55A52, 16'h5678, 0};
    vecs[6] = '{"rd3", 16'h0F01, 1, 24'h000052,
                3, 24'h0F0152, 16'h5678, 0};

    repeat (3) @(negedge clk);
    chk("rst_leds", leds, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx", uart_tx, 1);
    chk("rst_err", cmd_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // write timeout: no reply before 400 clocks, then 'T'
    switches = 16'hA55A;
    rx_q.delete();
    e0 = err_pls;
    n  = err_cyc;
    send_byte(8'h57);
    send_byte(8'h99);
    repeat (300) @(negedge clk);
    chk("to_early", rx_q.size(), 0);
    wait_rsp(1, 3000);
    repeat (120) @(negedge clk);
    chk("to_nrsp", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("to_b0", rx_q[0], 8'h54);
    chk("to_leds", leds, 16'h5678);
    chk("to_errp", err_pls - e0, 1);
    chk("to_errc", err_cyc - n, 1);

    // leds must change exactly one cycle after last rx_ready
    rx_q.delete();
    send_byte(8'h57);
    send_byte(8'hAB);
    fork
      send_byte(8'hCD);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!dut.rx_ready && n < 200);
        chk("wt_rdy", dut.rx_ready, 1);
        chk("wt_pre", leds, 16'h5678);
        @(negedge clk);
        chk("wt_post", leds, 16'hCDAB);
      end
    join
    wait_rsp(1, 3000);
    repeat (20) @(negedge clk);
    chk("wt_nrsp", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("wt_b0", rx_q[0], 8'h41);

    // reply start latency after a read command
    rx_q.delete();
    fork
      send_byte(8'h52);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!dut.rx_ready && n < 200);
        lat = 0;
        while (uart_tx && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        chk("lat_ok", (lat >= 1 && lat <= 3), 1);
      end
    join
    wait_rsp(3, 3000);
    repeat (120) @(negedge clk);
    chk("lat_nrsp", rx_q.size(), 3);

    // reset during second reply byte of a read
    rx_q.delete();
    send_byte(8'h52);
    wait_rsp(1, 3000);
    n = 0;
    while (uart_tx && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mr_2nd", uart_tx, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_tx", uart_tx, 1);
    chk("mr_leds", leds, 0);
    chk("mr_busy", busy, 0);
    chk("mr_err", cmd_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rx_q.delete();
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
